dsp_frame_loader: RTL and testbench

//  Upstream feeder for dsp_accelerator. Collects a valid/ready stream of 8-bit samples into 16-sample frames.

---
 rtl/dsp_pkg.sv | 33 +++
 rtl/dsp_frame_loader_if.sv | 40 ++++
 rtl/dsp_frame_bank.sv | 36 +++
 rtl/dsp_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_dsp_frame_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
//============================================================================
// dsp_pkg : shared constants, opcodes and dispatch-state encoding
// Rev 1.0
//============================================================================
`default_nettype none

package dsp_pkg;

    localparam int N_SAMPLES = 16;
    localparam int DW        = 8;
    localparam int IDX_W     = $clog2(N_SAMPLES);

    localparam logic [3:0] OP_FFT       = 4'd0;
    localparam logic [3:0] OP_IFFT      = 4'd1;
    localparam logic [3:0] OP_FIR       = 4'd2;
    localparam logic [3:0] OP_IIR       = 4'd3;
    localparam logic [3:0] OP_CONV      = 4'd4;
    localparam logic [3:0] OP_CORRELATE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } fsm_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_frame_loader_if.sv
//============================================================================
// dsp_frame_loader_if : sample stream, coefficient bus and accelerator link
// Rev 1.0
//============================================================================
`default_nettype none

interface dsp_frame_loader_if;
    import dsp_pkg::*;

    logic                    s_valid;
    logic [DW-1:0]           s_data;
    logic                    s_ready;
    logic                    flush;
    logic [3:0]              cfg_op;
    logic                    coef_we;
    logic [3:0]              coef_addr;
    logic [DW-1:0]           coef_wdata;
    logic                    acc_enable;
    logic [3:0]              acc_operation;
    logic [N_SAMPLES*DW-1:0] acc_data;
    logic [N_SAMPLES*DW-1:0] acc_coeff;
    logic                    acc_done;
    logic                    acc_error;

    // master: upstream source plus accelerator; slave: the loader itself
    modport master (
        output s_valid, s_data, flush, cfg_op, coef_we, coef_addr, coef_wdata,
               acc_done, acc_error,
        input  s_ready, acc_enable, acc_operation, acc_data, acc_coeff
    );

    modport slave (
        input  s_valid, s_data, flush, cfg_op, coef_we, coef_addr, coef_wdata,
               acc_done, acc_error,
        output s_ready, acc_enable, acc_operation, acc_data, acc_coeff
    );

endinterface

`default_nettype wire

// File: rtl/dsp_frame_bank.sv
//============================================================================
// dsp_frame_bank : one 16-sample frame buffer, single write port, flat read
// Rev 1.0
//============================================================================
`default_nettype none

module dsp_frame_bank
    import dsp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DW-1:0]           wdata,
    output logic [N_SAMPLES*DW-1:0] rdata
);

    logic [DW-1:0] r_mem [N_SAMPLES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                r_mem[k] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_flat
        assign rdata[i*DW +: DW] = r_mem[i];
    end

endmodule

`default_nettype wire

// File: rtl/dsp_frame_loader.sv
//============================================================================
// dsp_frame_loader : ping-pong frame collector and dispatcher for the DSP
//                    accelerator (issue, wait for done/error/timeout, cool)
// Rev 1.0
//============================================================================
`default_nettype none

module dsp_frame_loader
    import dsp_pkg::*;
#(
    parameter int DONE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    dsp_frame_loader_if.slave  bus,
    output logic               busy,
    output logic [31:0]        frame_count,
    output logic [15:0]        err_count,
    output logic               timeout_err
);

    localparam logic [7:0] C_TIMER_LAST = 8'(DONE_TIMEOUT - 1);

    logic [1:0]              r_full;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [IDX_W-1:0]        r_wr_idx;
    logic [3:0]              r_op [2];
    logic [DW-1:0]           r_coef [N_SAMPLES];
    logic [N_SAMPLES*DW-1:0] r_acc_coeff;
    logic                    r_acc_enable;
    fsm_state_t              r_state;
    logic [7:0]              r_timer;
    logic                    r_err_pend;

    logic [N_SAMPLES*DW-1:0] w_bank_rdata [2];
    logic                    w_accept;
    logic                    w_last;
    logic                    w_err_hit;
    logic                    w_wait_exit;

    // flush outranks a same-cycle sample, which is simply dropped
    assign bus.s_ready = ~r_full[r_wr_bank];
    assign w_accept    = bus.s_valid & bus.s_ready & ~bus.flush;
    assign w_last      = w_accept && (r_wr_idx == IDX_W'(N_SAMPLES - 1));

    // an error seen during ISSUE is carried into the first WAIT cycle
    assign w_err_hit   = r_err_pend | bus.acc_error;
    assign w_wait_exit = (r_state == ST_WAIT) &&
                         (w_err_hit || bus.acc_done || (r_timer == C_TIMER_LAST));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dsp_frame_bank u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_accept && (r_wr_bank == 1'(b))),
            .waddr (r_wr_idx),
            .wdata (bus.s_data),
            .rdata (w_bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_op[0]   <= '0;
            r_op[1]   <= '0;
        end else if (bus.flush) begin
            r_wr_idx <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_op[r_wr_bank] <= bus.cfg_op;
                r_wr_bank       <= ~r_wr_bank;
                r_wr_idx        <= '0;
            end else begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    // the fill side only sets a non-full bank, dispatch only clears a full one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= '0;
        end else begin
            if (w_last) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_wait_exit) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                r_coef[k] <= '0;
            end
        end else if (bus.coef_we) begin
            r_coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc_enable <= 1'b0;
            r_acc_coeff  <= '0;
            r_timer      <= '0;
            r_err_pend   <= 1'b0;
            r_rd_bank    <= 1'b0;
            frame_count  <= '0;
            err_count    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            r_acc_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        for (int k = 0; k < N_SAMPLES; k++) begin
                            r_acc_coeff[k*DW +: DW] <= r_coef[k];
                        end
                        r_acc_enable <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer    <= '0;
                    r_err_pend <= bus.acc_error;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_wait_exit) begin
                        if (w_err_hit) begin
                            err_count <= sat_inc16(err_count);
                        end else if (bus.acc_done) begin
                            frame_count <= frame_count + 32'd1;
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        r_err_pend <= 1'b0;
                        r_rd_bank  <= ~r_rd_bank;
                        r_state    <= ST_COOL;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                ST_COOL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.acc_enable    = r_acc_enable;
    assign bus.acc_coeff     = r_acc_coeff;
    assign bus.acc_data      = w_bank_rdata[r_rd_bank];
    assign bus.acc_operation = r_op[r_rd_bank];
    assign busy              = (r_state != ST_IDLE) || (|r_full);

endmodule

`default_nettype wire

// File: tb/tb_dsp_frame_loader.sv
//============================================================================
// tb_dsp_frame_loader : randomized scoreboard bench with accelerator model
// Rev 1.0
//============================================================================
`default_nettype none

module tb_dsp_frame_loader;
    import dsp_pkg::*;

    localparam int TO = 60;
    localparam int FW = N_SAMPLES * DW;

    localparam int R_DONE     = 0;
    localparam int R_ERR      = 1;
    localparam int R_BOTH     = 2;
    localparam int R_ISSUE    = 3;
    localparam int R_LATE_ERR = 4;
    localparam int R_NONE     = 5;

    typedef struct packed {
        logic [FW-1:0] data;
        logic [3:0]    op;
    } frame_t;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] frame_count;
    logic [15:0] err_count;
    logic        timeout_err;

    dsp_frame_loader_if bus ();

    dsp_frame_loader #(.DONE_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .frame_count (frame_count),
        .err_count   (err_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    frame_t        sb_q[$];
    resp_t         resp_q[$];
    logic [DW-1:0] cur[$];
    logic [DW-1:0] coef_m [N_SAMPLES];
    logic [FW-1:0] coef_prev = '0;
    logic [FW-1:0] last_coeff = '0;
    int            enable_cyc = -1;
    int            last_accept_cyc = 0;
    int            n_accepted = 0;
    int            stall_at = -1;
    int            exp_frames = 0;
    int            exp_errs = 0;
    logic          exp_to = 1'b0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_coef();
        logic [FW-1:0] v;
        for (int k = 0; k < N_SAMPLES; k++) v[k*DW +: DW] = coef_m[k];
        return v;
    endfunction

    function automatic void bump_err();
        if (exp_errs < 16'hFFFF) exp_errs++;
    endfunction

    // Monitor: every enable pops the oldest completed frame
    initial begin
        logic prev_en;
        frame_t e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.acc_enable) begin
                enable_cyc = cyc;
                last_coeff = bus.acc_coeff;
                check("enable_width", FW'(prev_en), FW'(1'b0));
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_enable: got enable expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("acc_data", bus.acc_data, e.data);
                    check("acc_operation", FW'(bus.acc_operation), FW'(e.op));
                    check("acc_coeff", bus.acc_coeff, coef_prev);
                end
            end
            prev_en   = bus.acc_enable;
            coef_prev = pack_coef();
        end
    end

    // Accelerator model: answers each enable from resp_q or at random
    initial begin
        resp_t r;
        bus.acc_done  = 1'b0;
        bus.acc_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.acc_enable) begin
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                end else begin
                    r.kind = 3'($urandom_range(0, 4));
                    r.lat  = 8'($urandom_range(1, 50));
                end
                if (int'(r.kind) == R_ISSUE) begin
                    bus.acc_error = 1'b1;
                    @(negedge clk);
                    bus.acc_error = 1'b0;
                    bump_err();
                end else if (int'(r.kind) == R_NONE) begin
                    exp_to = 1'b1;
                end else begin
                    repeat (int'(r.lat)) @(negedge clk);
                    bus.acc_done  = (int'(r.kind) != R_ERR);
                    bus.acc_error = (int'(r.kind) == R_ERR) || (int'(r.kind) == R_BOTH);
                    if (int'(r.kind) == R_DONE || int'(r.kind) == R_LATE_ERR) exp_frames++;
                    else bump_err();
                    @(negedge clk);
                    bus.acc_done  = 1'b0;
                    bus.acc_error = (int'(r.kind) == R_LATE_ERR);
                    @(negedge clk);
                    bus.acc_error = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [3:0] op);
        logic rdy;
        frame_t f;
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.cfg_op  = op;
        forever begin
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (stall_at < 0) stall_at = n_accepted;
            n++;
            if (n > 3000) break;
        end
        bus.s_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got stalled expected accept");
        end else begin
            n_accepted++;
            cur.push_back(d);
            if (cur.size() == N_SAMPLES) begin
                for (int i = 0; i < N_SAMPLES; i++) f.data[i*DW +: DW] = cur[i];
                f.op = op;
                sb_q.push_back(f);
                cur.delete();
                last_accept_cyc = cyc;
            end
        end
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [DW-1:0] v);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = a;
        bus.coef_wdata = v;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        coef_m[a]   = v;
    endtask

    task automatic do_flush();
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        cur.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_idle: got busy expected idle within 3000 cycles", name);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_frame_count"}, FW'(frame_count), FW'(32'(exp_frames)));
        check({name, "_err_count"}, FW'(err_count), FW'(16'(exp_errs)));
        check({name, "_timeout_err"}, FW'(timeout_err), FW'(exp_to));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1);
    end

    initial begin
        int n;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.flush      = 1'b0;
        bus.cfg_op     = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        for (int k = 0; k < N_SAMPLES; k++) coef_m[k] = '0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_s_ready", FW'(bus.s_ready), FW'(1'b1));
        check("rst_acc_enable", FW'(bus.acc_enable), FW'(1'b0));
        check("rst_frame_count", FW'(frame_count), FW'(32'd0));
        check("rst_busy", FW'(busy), FW'(1'b0));
        check("rst_err_count", FW'(err_count), FW'(16'd0));
        check("rst_acc_data", bus.acc_data, FW'(0));

        // single frame, coeffs all 1, done after 20 cycles
        for (int k = 0; k < N_SAMPLES; k++) write_coef(4'(k), 8'h01);
        resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd20});
        for (int i = 0; i < N_SAMPLES; i++) send(8'(i), OP_FIR);
        wait_idle("single");
        check("issue_latency", FW'(enable_cyc - last_accept_cyc), FW'(1));
        check("single_frame_count", FW'(frame_count), FW'(32'd1));
        check_counts("single");

        // 48 back-to-back samples, slow accelerator: fill stalls on bank reuse
        repeat (3) resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd40});
        n_accepted = 0;
        stall_at   = -1;
        for (int i = 0; i < 48; i++) send(8'(i * 7 + 3), 4'(i / 16));
        wait_idle("stream");
        check("stall_point", FW'(stall_at), FW'(32));
        check_counts("stream");

        // error in WAIT, then the queued frame still goes out
        resp_q.push_back('{kind: 3'(R_ERR), lat: 8'd5});
        resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd10});
        for (int i = 0; i < 32; i++) send(8'($urandom), OP_IIR);
        wait_idle("error");
        check_counts("error");

        // no response: timeout after exactly TO wait cycles, bank released
        resp_q.push_back('{kind: 3'(R_NONE), lat: 8'd0});
        resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd3});
        for (int i = 0; i < N_SAMPLES; i++) send(8'($urandom), OP_CONV);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.acc_enable && n < 100);
        check("timeout_enable_seen", FW'(bus.acc_enable), FW'(1'b1));
        repeat (TO) @(negedge clk);
        check("timeout_not_early", FW'(timeout_err), FW'(1'b0));
        @(negedge clk);
        check("timeout_set", FW'(timeout_err), FW'(1'b1));
        @(posedge clk);
        #1;
        for (int i = 0; i < N_SAMPLES; i++) send(8'($urandom), OP_FFT);
        wait_idle("timeout");
        check_counts("timeout");

        // coefficient write landing in the snapshot cycle
        resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd5});
        resp_q.push_back('{kind: 3'(R_DONE), lat: 8'd5});
        for (int i = 0; i < N_SAMPLES; i++) send(8'(255 - i), OP_CORRELATE);
        write_coef(4'd3, 8'hAA);
        wait_idle("snap_old");
        check("snap_old_byte3", FW'(last_coeff[3*DW +: DW]), FW'(8'h01));
        for (int i = 0; i < N_SAMPLES; i++) send(8'(i + 100), OP_FFT);
        wait_idle("snap_new");
        check("snap_new_byte3", FW'(last_coeff[3*DW +: DW]), FW'(8'hAA));

        // flush at wr_idx 7 with a colliding sample, then a clean frame
        for (int i = 0; i < 7; i++) send(8'(i + 50), OP_FIR);
        do_flush();
        for (int i = 0; i < N_SAMPLES; i++) send(8'(i + 200), OP_IFFT);
        wait_idle("flush");
        check_counts("flush");

        // randomized traffic
        for (int it = 0; it < 160; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) do_flush();
            else if (r < 10) write_coef(4'($urandom), 8'($urandom));
            else if (r < 20) begin
                @(posedge clk);
                #1;
            end else send(8'($urandom), 4'($urandom_range(0, 5)));
        end
        do_flush();
        wait_idle("random");
        check_counts("random");
        check("sb_empty", FW'(sb_q.size()), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
